instr_layer_sequencer: RTL and testbench

- Fetches one layer's instruction fields (INSTRUCTION_MEMORY_FIELDS words) from the flat single-port instruction SRAM into a shadow register bank.
- Presents the bank to control_unit and hands off with it layer by layer.
- Detects the stop layer and raises finished_network.
- Arbitrates the SRAM port between external programming writes and internal fetches; external writes always win.

---
 rtl/instr_layer_sequencer.sv | 167 ++++++++++++++++
 tb/tb_instr_layer_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_layer_sequencer.sv
// Layer sequencer: fetches one layer's instruction fields from a single-port SRAM
// into a shadow bank, launches it to control_unit and walks the network layer by layer.
module instr_layer_sequencer #(
  parameter int INSTRUCTION_MEMORY_WIDTH  = 16,
  parameter int INSTRUCTION_MEMORY_FIELDS = 24,
  parameter int INSTRUCTION_MEMORY_SIZE   = 32,
  parameter int IM_ADDR_BITS              = 10,
  parameter int STOP_FIELD                = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic                                start,
  input  logic                                EXECUTION_FRAME_BY_FRAME,
  input  logic                                wr_en_ext_im,
  input  logic [IM_ADDR_BITS-1:0]             wr_addr_ext_im,
  input  logic [INSTRUCTION_MEMORY_WIDTH-1:0] wr_data_ext_im,
  output logic                                im_en,
  output logic                                im_we,
  output logic [IM_ADDR_BITS-1:0]             im_addr,
  output logic [INSTRUCTION_MEMORY_WIDTH-1:0] im_wdata,
  input  logic [INSTRUCTION_MEMORY_WIDTH-1:0] im_rdata,
  output logic [INSTRUCTION_MEMORY_FIELDS-1:0][INSTRUCTION_MEMORY_WIDTH-1:0] instruction,
  output logic                                layer_start,
  output logic                                layer_active,
  input  logic                                layer_done,
  output logic [31:0]                         PC,
  output logic                                finished_network,
  output logic                                busy,
  output logic [2:0]                          state_dbg
);

  localparam int F  = INSTRUCTION_MEMORY_FIELDS;
  localparam int IW = $clog2(F + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_LAUNCH  = 3'd2;
  localparam logic [2:0] S_RUNNING = 3'd3;
  localparam logic [2:0] S_END     = 3'd4;

  localparam logic [IW-1:0]           FIELD_CNT = IW'(F);
  localparam logic [IW-1:0]           LAST_IDX  = IW'(F - 1);
  localparam logic [IM_ADDR_BITS-1:0] BASE_STEP = IM_ADDR_BITS'(F);
  localparam logic [31:0]             PC_MAX    = 32'(INSTRUCTION_MEMORY_SIZE - 1);

  logic [2:0]              state;
  logic [IW-1:0]           issue_idx;
  logic [IW-1:0]           cap_idx;
  logic                    pending;
  logic [IM_ADDR_BITS-1:0] base;
  logic                    fetch_grant;

  // Handshake: a read granted in cycle n (fetch_grant=1) returns im_rdata in
  // cycle n+1, where the pending flag captures it into instruction[cap_idx].
  // External writes take the port unconditionally; they only delay new issues.
  assign fetch_grant = (state == S_FETCH) && !wr_en_ext_im && (issue_idx < FIELD_CNT);

  always_comb begin
    im_en    = 1'b0;
    im_we    = 1'b0;
    im_addr  = '0;
    im_wdata = '0;
    if (wr_en_ext_im) begin
      im_en    = 1'b1;
      im_we    = 1'b1;
      im_addr  = wr_addr_ext_im;
      im_wdata = wr_data_ext_im;
    end else if (fetch_grant) begin
      im_en   = 1'b1;
      im_addr = base + IM_ADDR_BITS'(issue_idx);
    end
  end

  assign busy      = (state != S_IDLE) && (state != S_END);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= S_IDLE;
      issue_idx        <= '0;
      cap_idx          <= '0;
      pending          <= 1'b0;
      base             <= '0;
      PC               <= '0;
      instruction      <= '0;
      layer_start      <= 1'b0;
      layer_active     <= 1'b0;
      finished_network <= 1'b0;
    end else if (!enable) begin
      // Abort keeps the bank but drops any in-flight capture.
      state            <= S_IDLE;
      issue_idx        <= '0;
      cap_idx          <= '0;
      pending          <= 1'b0;
      base             <= '0;
      PC               <= '0;
      layer_start      <= 1'b0;
      layer_active     <= 1'b0;
      finished_network <= 1'b0;
    end else begin
      layer_start <= 1'b0;
      pending     <= fetch_grant;
      if (fetch_grant) begin
        cap_idx   <= issue_idx;
        issue_idx <= issue_idx + 1'b1;
      end
      if (pending) begin
        instruction[cap_idx] <= im_rdata;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_FETCH;
            PC        <= '0;
            base      <= '0;
            issue_idx <= '0;
            cap_idx   <= '0;
          end
        end
        S_FETCH: begin
          if (pending && (cap_idx == LAST_IDX)) begin
            state       <= S_LAUNCH;
            layer_start <= 1'b1;
          end
        end
        S_LAUNCH: begin
          if (instruction[STOP_FIELD][0]) begin
            state            <= S_END;
            finished_network <= 1'b1;
          end else begin
            state        <= S_RUNNING;
            layer_active <= 1'b1;
          end
        end
        S_RUNNING: begin
          if (layer_done) begin
            layer_active <= 1'b0;
            if (PC == PC_MAX) begin
              state            <= S_END;
              finished_network <= 1'b1;
            end else begin
              state     <= S_FETCH;
              PC        <= PC + 32'd1;
              base      <= base + BASE_STEP;
              issue_idx <= '0;
              cap_idx   <= '0;
            end
          end
        end
        S_END: begin
          if (EXECUTION_FRAME_BY_FRAME && start) begin
            state            <= S_FETCH;
            finished_network <= 1'b0;
            PC               <= '0;
            base             <= '0;
            issue_idx        <= '0;
            cap_idx          <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_layer_sequencer.sv
// Bench for instr_layer_sequencer: SRAM model, random programs and a
// layer-level reference model of which bank each launch must present.
module tb_instr_layer_sequencer;

  localparam int W     = 16;
  localparam int F     = 24;
  localparam int SIZE  = 32;
  localparam int AB    = 10;
  localparam int STOPF = 0;
  localparam int BW    = F * W;
  localparam int LAT   = F + 2;
  localparam int STALL_ADDR = 1000;
  localparam logic [W-1:0] STALL_DATA = 16'hA000;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic            start;
  logic            fbf;
  logic            wr_en;
  logic [AB-1:0]   wr_addr;
  logic [W-1:0]    wr_data;
  logic            im_en;
  logic            im_we;
  logic [AB-1:0]   im_addr;
  logic [W-1:0]    im_wdata;
  logic [W-1:0]    im_rdata;
  logic [F-1:0][W-1:0] instruction;
  logic            layer_start;
  logic            layer_active;
  logic            layer_done;
  logic [31:0]     PC;
  logic            finished_network;
  logic            busy;
  logic [2:0]      state_dbg;

  logic [W-1:0] sram    [1024];
  logic [W-1:0] ref_mem [1024];
  int n_checks = 0;
  int n_pass   = 0;

  instr_layer_sequencer dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start),
    .EXECUTION_FRAME_BY_FRAME(fbf),
    .wr_en_ext_im(wr_en), .wr_addr_ext_im(wr_addr), .wr_data_ext_im(wr_data),
    .im_en(im_en), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .im_rdata(im_rdata), .instruction(instruction),
    .layer_start(layer_start), .layer_active(layer_active), .layer_done(layer_done),
    .PC(PC), .finished_network(finished_network), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (im_en) begin
      if (im_we) sram[im_addr] <= im_wdata;
      else       im_rdata      <= sram[im_addr];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference model: a layer's bank is simply its slice of the program image
  function automatic logic [BW-1:0] model_bank(input int l);
    logic [BW-1:0] b;
    for (int i = 0; i < F; i++) b[i*W +: W] = ref_mem[l*F + i];
    return b;
  endfunction

  function automatic int model_stop();
    for (int l = 0; l < SIZE; l++)
      if (ref_mem[l*F + STOPF][0]) return l;
    return -1;
  endfunction

  // driver tasks
  task automatic write_word(input int a, input logic [W-1:0] d);
    wr_en = 1'b1; wr_addr = AB'(a); wr_data = d;
    ref_mem[a] = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic load_program(input int stop_l, input bit directed);
    logic [W-1:0] d;
    for (int a = 0; a < SIZE*F; a++) begin
      d = W'($urandom);
      if (directed && (a / F) == 0) d = W'(16'h100 + a);
      if ((a % F) == STOPF) d[0] = ((a / F) == stop_l);
      write_word(a, d);
    end
  endtask

  task automatic go_idle();
    enable = 1'b0;
    step();
    enable = 1'b1;
  endtask

  task automatic wait_launch(input int exp_lat, input bit stall, output bit ok);
    int cyc;
    cyc = 0;
    ok  = 1'b0;
    while (cyc < 200) begin
      step();
      cyc++;
      start = 1'b0;
      layer_done = 1'b0;
      if (stall && cyc >= 5 && cyc <= 7) begin
        wr_en = 1'b1; wr_addr = AB'(STALL_ADDR); wr_data = STALL_DATA + W'(cyc);
        ref_mem[STALL_ADDR] = STALL_DATA + W'(cyc);
        #1;
        check("stall_en", im_en, 1);
        check("stall_we", im_we, 1);
        check("stall_addr", im_addr, STALL_ADDR);
      end else begin
        wr_en = 1'b0;
      end
      if (layer_start) begin
        ok = 1'b1;
        break;
      end
    end
    wr_en = 1'b0;
    check("launch_latency", cyc, exp_lat);
  endtask

  task automatic run_net(input bit stall0, input int abort_pc);
    int stop_l;
    bit ok;
    logic [BW-1:0] bank;
    stop_l = model_stop();
    start = 1'b1;
    for (int l = 0; l < SIZE; l++) begin
      wait_launch((stall0 && l == 0) ? LAT + 3 : LAT, stall0 && l == 0, ok);
      if (!ok) return;
      bank = model_bank(l);
      check("launch_pc", PC, l);
      check("launch_bank", instruction, bank);
      step();
      check("start_pulse_width", layer_start, 0);
      if (l == stop_l) begin
        check("stop_finished", finished_network, 1);
        check("stop_not_active", layer_active, 0);
        check("stop_busy", busy, 0);
        return;
      end
      check("run_active", layer_active, 1);
      check("run_busy", busy, 1);
      if (l == abort_pc) begin
        enable = 1'b0; layer_done = 1'b1;
        step();
        enable = 1'b1; layer_done = 1'b0;
        check("abort_pc", PC, 0);
        check("abort_active", layer_active, 0);
        check("abort_busy", busy, 0);
        check("abort_finished", finished_network, 0);
        check("abort_bank_kept", instruction, bank);
        layer_done = 1'b1;
        step();
        layer_done = 1'b0;
        step();
        check("idle_done_busy", busy, 0);
        check("idle_done_pc", PC, 0);
        check("idle_done_launch", layer_start, 0);
        check("idle_done_bank", instruction, bank);
        return;
      end
      repeat ($urandom_range(0, 4)) begin
        start = ($urandom_range(0, 2) == 0);
        step();
      end
      start = 1'b0;
      check("frozen_bank", instruction, bank);
      check("run_pc", PC, l);
      check("run_still_active", layer_active, 1);
      layer_done = 1'b1;
      if (l == SIZE - 1) begin
        step();
        layer_done = 1'b0;
        check("last_finished", finished_network, 1);
        check("last_pc", PC, SIZE - 1);
        check("last_busy", busy, 0);
        check("last_active", layer_active, 0);
        repeat (5) step();
        check("no_wrap_pc", PC, SIZE - 1);
        check("no_wrap_finished", finished_network, 1);
      end
    end
  endtask

  initial begin
    bit ok;
    int seen;
    foreach (sram[i]) begin
      sram[i] = '0;
      ref_mem[i] = '0;
    end
    reset = 1'b1; enable = 1'b1; start = 1'b0; fbf = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; layer_done = 1'b0;
    repeat (3) step();
    check("rst_pc", PC, 0);
    check("rst_bank", instruction, 0);
    check("rst_busy", busy, 0);
    check("rst_finished", finished_network, 0);
    check("rst_active", layer_active, 0);
    check("rst_im_en", im_en, 0);
    reset = 1'b0;
    step();

    // directed two-layer network: layer 1 carries STOP
    load_program(1, 1'b1);
    check("ext_write_landed0", sram[5], ref_mem[5]);
    run_net(1'b0, -1);
    go_idle();

    // same network with an external write stalling fetch
    run_net(1'b1, -1);
    check("ext_write_landed", sram[STALL_ADDR], ref_mem[STALL_ADDR]);
    go_idle();

    // frame-by-frame re-arm from END
    fbf = 1'b1;
    run_net(1'b0, -1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("fbf_finished_drop", finished_network, 0);
    check("fbf_pc", PC, 0);
    check("fbf_busy", busy, 1);
    wait_launch(LAT - 1, 1'b0, ok);
    check("fbf_bank", instruction, model_bank(0));
    step();
    check("fbf_active", layer_active, 1);
    go_idle();

    // without frame-by-frame, start in END is ignored
    fbf = 1'b0;
    run_net(1'b0, -1);
    start = 1'b1;
    step();
    start = 1'b0;
    seen = 0;
    repeat (30) begin
      step();
      if (layer_start || busy) seen++;
    end
    check("end_hold_activity", seen, 0);
    check("end_hold_finished", finished_network, 1);
    go_idle();

    // full 32 layers with no STOP anywhere
    load_program(-1, 1'b0);
    run_net(1'b0, -1);
    go_idle();

    // abort in RUNNING at PC=2, colliding with layer_done
    run_net(1'b0, 2);

    // asynchronous reset mid-fetch
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    #2 reset = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_im_en", im_en, 0);
    check("arst_bank", instruction, 0);
    check("arst_pc", PC, 0);
    check("arst_start", layer_start, 0);
    #3 reset = 1'b0;
    step();
    load_program(3, 1'b0);
    run_net(1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
